fmul7_arbiter: RTL
==================

FMUL7_ARBITER -- requirements
Module: fmul7_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req0_valid, req1_valid  in  1 each  requester has an operand pair pending.
REQ-006 req0_ready, req1_ready  out  1 each  pair accepted this cycle.
REQ-007 a0, b0, a1, b1  in  7 each  operands, format {exp[6:4], frac[3:0]}: bias 3, implicit leading 1, no zero/subnormal encoding.
REQ-008 res  out  7  product.
REQ-009 res_valid  out  1  res, res_id and flags are valid.
REQ-010 res_ready  in  1  consumer accepts result.
REQ-011 res_id  out  1  index of the requester that owns res.
REQ-012 res_ovf, res_unf  out  1 each  result saturated high / flushed low.
REQ-013 op_cnt  out  8  count of completed result handshakes.

Function
REQ-014 FSM states: IDLE, CALC, DONE.
REQ-015 IDLE: winner = the requester with valid high; if both are valid, the winner is the one at the RR pointer (RR_EN=1) or requester 0 (RR_EN=0); only the winner sees ready high, combinationally, in the same cycle.
REQ-016 Accept (valid & ready): operands and id are registered; state -> CALC; the RR pointer moves to the other requester.
REQ-017 CALC: product computed from the registered operands; res/flags/id registered; state -> DONE.
REQ-018 DONE: res_valid=1; res, res_id and flags held stable until res_ready=1; on handshake, op_cnt increments (wraps 255->0) and state -> IDLE.
REQ-019 Both ready outputs are 0 in CALC and DONE; latency from accept to res_valid is 2 cycles; minimum issue interval is 3 cycles.
REQ-020 Arithmetic: ma={1,fa}, mb={1,fb}, P=ma*mb (10 bits); n=P[9].
- If n=1: frac=P[8:5], rbit=P[4].
- If n=0: frac=P[7:4], rbit=P[3].
REQ-021 Rounding is round-half-up: {cy,frac'}=frac+rbit; if cy=1, frac'=0000.
REQ-022 Exponent is computed signed, at least 5 bits: e=ea+eb-3+n+cy.
REQ-023 e>7 -> res=1111111, res_ovf=1.
REQ-024 e<0 -> res=0000000, res_unf=1.
REQ-025 Otherwise res={e[2:0], frac'} and both flags are 0.
REQ-026 A requester that drops valid before being accepted is not served; operand changes after acceptance have no effect.

Reset
REQ-027 When rst=1 on a clock edge:
- state=IDLE; RR pointer=0.
- res=0, res_id=0, res_ovf=0, res_unf=0, res_valid=0, op_cnt=0.
REQ-028 Reset in CALC or DONE discards the in-flight operation, and no handshake is counted.
REQ-029 While rst=1, both ready outputs are 0.

Structure
REQ-030 The shared package fmul7_pkg holds:
- field widths EXP_W=3, FRAC_W=4, constant BIAS=3;
- saturation constants MAX_VAL=7'b1111111, ZERO_VAL=7'b0000000;
- the state enum.
REQ-031 The arithmetic of REQ-020 to REQ-025 lives in one combinational sub-module fmul7_core (inputs a, b; outputs res, ovf, unf), instantiated once; the arbiter contains only sequencing and registers.

Verification
REQ-032 Single request: req0 a0=0111010, b0=0111010 -> req0_ready in the same cycle; 2 cycles later res=1000101 (2.625), res_id=0, both flags 0.
REQ-033 Rounding: a=1011010, b=0011101 -> res=1001000 (3.0); rounding with carry: a=0111000, b=0110101 -> res=1000000 (2.0).
REQ-034 Saturation:
- a=b=1111111 -> res=1111111, res_ovf=1;
- a=b=0000000 -> res=0000000, res_unf=1.
REQ-035 Arbitration: both valid continuously after reset, RR_EN=1 -> grants 0,1,0,1; with RR_EN=0 -> grants 0,0,0.
REQ-036 Back-pressure: res_ready=0 for 5 cycles in DONE -> res and res_id stable, both ready outputs 0, op_cnt unchanged; when res_ready rises, op_cnt+1.
REQ-037 Reset mid-operation: rst asserted in CALC -> next cycle res_valid=0, op_cnt=0, state IDLE.
REQ-038 Counter wrap: 256 completed handshakes -> op_cnt returns to 0.

Source files
------------

// File: rtl/fmul7_pkg.sv
// Shared definitions for the 7-bit float multiplier arbiter slice:
// operand field widths, saturation constants and the sequencer state encoding.
package fmul7_pkg;

  localparam int EXP_W  = 3;
  localparam int FRAC_W = 4;
  localparam int BIAS   = 3;
  localparam int VAL_W  = EXP_W + FRAC_W;

  localparam logic [VAL_W-1:0] MAX_VAL  = 7'b1111111;
  localparam logic [VAL_W-1:0] ZERO_VAL = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/fmul7_core.sv
// Combinational 7-bit float multiply: implicit-one mantissas, round-half-up,
// saturate high on exponent overflow and flush to zero on underflow.
module fmul7_core
  import fmul7_pkg::*;
(
  input  logic [VAL_W-1:0] a,
  input  logic [VAL_W-1:0] b,
  output logic [VAL_W-1:0] res,
  output logic             ovf,
  output logic             unf
);

  logic [FRAC_W:0]     ma_s;
  logic [FRAC_W:0]     mb_s;
  logic [9:0]          p_s;
  logic                n_s;
  logic [FRAC_W:0]     p_sh_s;
  logic [FRAC_W-1:0]   frac_s;
  logic                rbit_s;
  logic                cy_s;
  logic [FRAC_W-1:0]   frac_rnd_s;
  logic signed [5:0]   e_s;

  // Mantissa product, normalisation, rounding and exponent range handling
  always_comb begin
    ma_s = {1'b1, a[FRAC_W-1:0]};
    mb_s = {1'b1, b[FRAC_W-1:0]};
    p_s  = {5'b00000, ma_s} * {5'b00000, mb_s};
    n_s  = p_s[9];
    // p_sh_s holds the four kept fraction bits followed by the round bit
    if (n_s) begin
      p_sh_s = 5'(p_s >> 4);
    end else begin
      p_sh_s = 5'(p_s >> 3);
    end
    frac_s = p_sh_s[4:1];
    rbit_s = p_sh_s[0];
    {cy_s, frac_rnd_s} = {1'b0, frac_s} + {4'b0000, rbit_s};
    e_s = $signed({3'b000, a[VAL_W-1:FRAC_W]}) + $signed({3'b000, b[VAL_W-1:FRAC_W]})
        - $signed(6'(BIAS)) + $signed({5'b00000, n_s}) + $signed({5'b00000, cy_s});
    res = ZERO_VAL;
    ovf = 1'b0;
    unf = 1'b0;
    if (e_s > 6'sd7) begin
      res = MAX_VAL;
      ovf = 1'b1;
    end else if (e_s < 6'sd0) begin
      res = ZERO_VAL;
      unf = 1'b1;
    end else begin
      res = {e_s[2:0], frac_rnd_s};
    end
  end

endmodule

// File: rtl/fmul7_arbiter.sv
// Two-requester front end for fmul7_core: picks a winner in IDLE, registers
// its operands, computes in CALC and holds the result in DONE until taken.
module fmul7_arbiter
  import fmul7_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [VAL_W-1:0] a0,
  input  logic [VAL_W-1:0] b0,
  input  logic [VAL_W-1:0] a1,
  input  logic [VAL_W-1:0] b1,
  output logic [VAL_W-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_ovf,
  output logic             res_unf,
  output logic [7:0]       op_cnt
);

  state_e            state_r;
  state_e            state_next_s;
  logic              rr_ptr_r;
  logic              grant_any_s;
  logic              grant_id_s;
  logic [VAL_W-1:0]  op_a_r;
  logic [VAL_W-1:0]  op_b_r;
  logic              op_id_r;
  logic [VAL_W-1:0]  core_res_s;
  logic              core_ovf_s;
  logic              core_unf_s;
  logic [VAL_W-1:0]  res_r;
  logic              res_valid_r;
  logic              res_id_r;
  logic              res_ovf_r;
  logic              res_unf_r;
  logic [7:0]        op_cnt_r;

  fmul7_core u_core (
    .a   (op_a_r),
    .b   (op_b_r),
    .res (core_res_s),
    .ovf (core_ovf_s),
    .unf (core_unf_s)
  );

  // Winner selection; grants are only offered in IDLE and never during reset
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = RR_EN ? rr_ptr_r : 1'b0;
      end else if (req0_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = 1'b0;
      end else if (req1_valid) begin
        grant_any_s = 1'b1;
        grant_id_s  = 1'b1;
      end else begin
        grant_any_s = 1'b0;
        grant_id_s  = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
      grant_id_s  = 1'b0;
    end
    req0_ready = grant_any_s && !grant_id_s;
    req1_ready = grant_any_s && grant_id_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = grant_any_s ? CALC : IDLE;
      CALC:    state_next_s = DONE;
      DONE:    state_next_s = res_ready ? IDLE : DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand capture, result registers and handshake counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 1'b0;
      op_a_r      <= ZERO_VAL;
      op_b_r      <= ZERO_VAL;
      op_id_r     <= 1'b0;
      res_r       <= ZERO_VAL;
      res_valid_r <= 1'b0;
      res_id_r    <= 1'b0;
      res_ovf_r   <= 1'b0;
      res_unf_r   <= 1'b0;
      op_cnt_r    <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == IDLE) && grant_any_s) begin
        op_a_r   <= grant_id_s ? a1 : a0;
        op_b_r   <= grant_id_s ? b1 : b0;
        op_id_r  <= grant_id_s;
        rr_ptr_r <= ~grant_id_s;
      end
      if (state_r == CALC) begin
        res_r       <= core_res_s;
        res_ovf_r   <= core_ovf_s;
        res_unf_r   <= core_unf_s;
        res_id_r    <= op_id_r;
        res_valid_r <= 1'b1;
      end
      if ((state_r == DONE) && res_ready) begin
        res_valid_r <= 1'b0;
        op_cnt_r    <= op_cnt_r + 8'd1;
      end
    end
  end

  assign res       = res_r;
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_ovf   = res_ovf_r;
  assign res_unf   = res_unf_r;
  assign op_cnt    = op_cnt_r;

endmodule
